// File: rtl/bank_biu_burst.sv
// bank_biu_burst: bank bus interface unit. It queues HTU line-fill and write-back
// requests in one ordered FIFO and issues them as AXI3 INCR bursts. It also
// sequences SC write beats with a generated WLAST and limits outstanding bursts.
// Optional build macro: BIU_ERR_CAPTURE_EN latches the ID and response of the first error.
module bank_biu_burst #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned SW_WIDTH   = 6,
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned MAX_OUTST  = 4,
  localparam int unsigned LOB       = $clog2(BURST_LEN * DATA_WIDTH / 8),
  localparam int unsigned LA_W      = ADDR_WIDTH - LOB,
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // HTU request side
  input  logic                  htu_biu_arvalid_i,
  output logic                  htu_biu_arready_o,
  input  logic [LA_W-1:0]       htu_biu_araddr_i,
  input  logic                  htu_biu_awvalid_i,
  output logic                  htu_biu_awready_o,
  input  logic [LA_W-1:0]       htu_biu_awaddr_i,
  input  logic [SW_WIDTH-1:0]   htu_biu_set_way_i,
  // SC write beats
  input  logic                  sc_biu_valid_i,
  output logic                  sc_biu_ready_o,
  input  logic [DATA_WIDTH-1:0] sc_biu_data_i,
  input  logic [STRB_W-1:0]     sc_biu_strb_i,
  input  logic [SW_WIDTH-1:0]   sc_biu_set_way_i,
  // ISU read beats
  output logic                  biu_isu_rvalid_o,
  input  logic                  biu_isu_rready_i,
  output logic [DATA_WIDTH-1:0] biu_isu_rdata_o,
  output logic [ID_WIDTH-1:0]   biu_isu_rid_o,
  output logic                  biu_isu_rlast_o,
  // AXI3 AR
  output logic                  biu_axi3_arvalid_o,
  input  logic                  biu_axi3_arready_i,
  output logic [ID_WIDTH-1:0]   biu_axi3_arid_o,
  output logic [ADDR_WIDTH-1:0] biu_axi3_araddr_o,
  output logic [3:0]            biu_axi3_arlen_o,
  output logic [2:0]            biu_axi3_arsize_o,
  output logic [1:0]            biu_axi3_arburst_o,
  // AXI3 R
  input  logic                  biu_axi3_rvalid_i,
  output logic                  biu_axi3_rready_o,
  input  logic [ID_WIDTH-1:0]   biu_axi3_rid_i,
  input  logic [DATA_WIDTH-1:0] biu_axi3_rdata_i,
  input  logic [1:0]            biu_axi3_rresp_i,
  input  logic                  biu_axi3_rlast_i,
  // AXI3 AW
  output logic                  biu_axi3_awvalid_o,
  input  logic                  biu_axi3_awready_i,
  output logic [ID_WIDTH-1:0]   biu_axi3_awid_o,
  output logic [ADDR_WIDTH-1:0] biu_axi3_awaddr_o,
  output logic [3:0]            biu_axi3_awlen_o,
  output logic [2:0]            biu_axi3_awsize_o,
  output logic [1:0]            biu_axi3_awburst_o,
  // AXI3 W
  output logic                  biu_axi3_wvalid_o,
  input  logic                  biu_axi3_wready_i,
  output logic [ID_WIDTH-1:0]   biu_axi3_wid_o,
  output logic [DATA_WIDTH-1:0] biu_axi3_wdata_o,
  output logic [STRB_W-1:0]     biu_axi3_wstrb_o,
  output logic                  biu_axi3_wlast_o,
  // AXI3 B
  input  logic                  biu_axi3_bvalid_i,
  output logic                  biu_axi3_bready_o,
  input  logic [ID_WIDTH-1:0]   biu_axi3_bid_i,
  input  logic [1:0]            biu_axi3_bresp_i,
  // Error reporting
  output logic                  biu_err_o,
  output logic [ID_WIDTH-1:0]   biu_err_id_o,
  output logic [1:0]            biu_err_resp_o
);

  localparam int unsigned SZ     = $clog2(DATA_WIDTH / 8);
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned FCNT_W = FIFO_AW + 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef struct packed {
    logic                is_wr;
    logic [SW_WIDTH-1:0] set_way;
    logic [LA_W-1:0]     line;
  } req_t;

  req_t                r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wptr;
  logic [FIFO_AW-1:0]  r_rptr;
  logic [FCNT_W-1:0]   r_count;
  logic [CNT_W-1:0]    r_rd_outst;
  logic [CNT_W-1:0]    r_wr_outst;
  logic [CNT_W-1:0]    r_wpend;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_bready;
  logic                r_err;

  logic                w_ready;
  logic                w_push_aw;
  logic                w_push_ar;
  logic [FCNT_W-1:0]   w_push_n;
  req_t                w_aw_req;
  req_t                w_ar_req;
  req_t                w_head;
  logic                w_head_vld;
  logic                w_arvalid;
  logic                w_awvalid;
  logic                w_ar_hs;
  logic                w_aw_hs;
  logic                w_pop;
  logic                w_r_hs;
  logic                w_r_done;
  logic                w_wpend_nz;
  logic                w_wvalid;
  logic                w_wlast;
  logic                w_w_hs;
  logic                w_w_done;
  logic                w_b_hs;
  logic                w_r_err;
  logic                w_b_err;

  // Request intake: both channels accepted only while two slots are free
  assign w_ready   = (r_count <= FCNT_W'(DEPTH - 2));
  assign w_push_aw = htu_biu_awvalid_i & w_ready;
  assign w_push_ar = htu_biu_arvalid_i & w_ready;
  assign w_push_n  = FCNT_W'(w_push_aw) + FCNT_W'(w_push_ar);
  assign w_aw_req  = '{is_wr: 1'b1, set_way: htu_biu_set_way_i, line: htu_biu_awaddr_i};
  assign w_ar_req  = '{is_wr: 1'b0, set_way: htu_biu_set_way_i, line: htu_biu_araddr_i};

  assign htu_biu_arready_o = w_ready;
  assign htu_biu_awready_o = w_ready;

  // In-order issue from the FIFO head
  assign w_head     = r_mem[r_rptr];
  assign w_head_vld = (r_count != '0);
  assign w_arvalid  = w_head_vld & ~w_head.is_wr & (r_rd_outst < CNT_W'(MAX_OUTST));
  assign w_awvalid  = w_head_vld &  w_head.is_wr & (r_wr_outst < CNT_W'(MAX_OUTST))
                      & (r_wpend < CNT_W'(MAX_OUTST));
  assign w_ar_hs    = w_arvalid & biu_axi3_arready_i;
  assign w_aw_hs    = w_awvalid & biu_axi3_awready_i;
  assign w_pop      = w_ar_hs | w_aw_hs;

  assign biu_axi3_arvalid_o = w_arvalid;
  assign biu_axi3_arid_o    = ID_WIDTH'(w_head.set_way);
  assign biu_axi3_araddr_o  = {w_head.line, {LOB{1'b0}}};
  assign biu_axi3_arlen_o   = 4'(BURST_LEN - 1);
  assign biu_axi3_arsize_o  = 3'(SZ);
  assign biu_axi3_arburst_o = 2'b01;

  assign biu_axi3_awvalid_o = w_awvalid;
  assign biu_axi3_awid_o    = ID_WIDTH'(w_head.set_way);
  assign biu_axi3_awaddr_o  = {w_head.line, {LOB{1'b0}}};
  assign biu_axi3_awlen_o   = 4'(BURST_LEN - 1);
  assign biu_axi3_awsize_o  = 3'(SZ);
  assign biu_axi3_awburst_o = 2'b01;

  // R channel passes straight through to the ISU
  assign biu_isu_rvalid_o  = biu_axi3_rvalid_i;
  assign biu_isu_rdata_o   = biu_axi3_rdata_i;
  assign biu_isu_rid_o     = biu_axi3_rid_i;
  assign biu_isu_rlast_o   = biu_axi3_rlast_i;
  assign biu_axi3_rready_o = biu_isu_rready_i;
  assign w_r_hs            = biu_axi3_rvalid_i & biu_isu_rready_i;
  assign w_r_done          = w_r_hs & biu_axi3_rlast_i;

  // W channel: beats are held back until their AW has been issued
  assign w_wpend_nz        = (r_wpend != '0);
  assign w_wvalid          = sc_biu_valid_i & w_wpend_nz;
  assign w_wlast           = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_w_hs            = w_wvalid & biu_axi3_wready_i;
  assign w_w_done          = w_w_hs & w_wlast;
  assign sc_biu_ready_o    = biu_axi3_wready_i & w_wpend_nz;
  assign biu_axi3_wvalid_o = w_wvalid;
  assign biu_axi3_wlast_o  = w_wlast;
  assign biu_axi3_wid_o    = ID_WIDTH'(sc_biu_set_way_i);
  assign biu_axi3_wdata_o  = sc_biu_data_i;
  assign biu_axi3_wstrb_o  = sc_biu_strb_i;

  assign w_b_hs            = biu_axi3_bvalid_i & r_bready;
  assign biu_axi3_bready_o = r_bready;

  assign w_r_err   = w_r_hs & (biu_axi3_rresp_i != 2'b00);
  assign w_b_err   = w_b_hs & (biu_axi3_bresp_i != 2'b00);
  assign biu_err_o = r_err;

  // FIFO storage; the AW entry takes the older slot when both push together
  always_ff @(posedge clk_i) begin
    if (w_push_aw) r_mem[r_wptr] <= w_aw_req;
    if (w_push_ar) r_mem[r_wptr + FIFO_AW'(w_push_aw)] <= w_ar_req;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + FIFO_AW'(w_push_n);
      r_rptr  <= r_rptr + FIFO_AW'(w_pop);
      r_count <= r_count + w_push_n - FCNT_W'(w_pop);
    end
  end

  // Outstanding-burst counters; simultaneous +1/-1 cancel out
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_outst <= '0;
      r_wr_outst <= '0;
      r_wpend    <= '0;
    end else begin
      if (w_ar_hs && !w_r_done)      r_rd_outst <= r_rd_outst + CNT_W'(1);
      else if (!w_ar_hs && w_r_done) r_rd_outst <= r_rd_outst - CNT_W'(1);
      if (w_aw_hs && !w_b_hs)        r_wr_outst <= r_wr_outst + CNT_W'(1);
      else if (!w_aw_hs && w_b_hs)   r_wr_outst <= r_wr_outst - CNT_W'(1);
      if (w_aw_hs && !w_w_done)      r_wpend    <= r_wpend + CNT_W'(1);
      else if (!w_aw_hs && w_w_done) r_wpend    <= r_wpend - CNT_W'(1);
    end
  end

  // W beat position within the current burst, wrapping after WLAST
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_beat <= '0;
    else if (w_w_hs) r_beat <= w_wlast ? '0 : r_beat + BEAT_W'(1);
  end

  // B is always accepted once out of reset; error flag is sticky
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bready <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_bready <= 1'b1;
      if (w_r_err || w_b_err) r_err <= 1'b1;
    end
  end

`ifdef BIU_ERR_CAPTURE_EN
  logic [ID_WIDTH-1:0] r_err_id;
  logic [1:0]          r_err_resp;

  // Capture only the first error; R takes priority over B in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_id   <= '0;
      r_err_resp <= '0;
    end else if (!r_err && w_r_err) begin
      r_err_id   <= biu_axi3_rid_i;
      r_err_resp <= biu_axi3_rresp_i;
    end else if (!r_err && w_b_err) begin
      r_err_id   <= biu_axi3_bid_i;
      r_err_resp <= biu_axi3_bresp_i;
    end
  end

  assign biu_err_id_o   = r_err_id;
  assign biu_err_resp_o = r_err_resp;
`else
  logic w_unused_bid;
  assign w_unused_bid   = ^biu_axi3_bid_i;
  assign biu_err_id_o   = '0;
  assign biu_err_resp_o = '0;
`endif

endmodule

// File: tb/tb_bank_biu_burst.sv
// Self-checking bench for bank_biu_burst (default parameters, BURST_LEN=2).
module tb_bank_biu_burst;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 256;
  localparam int unsigned IW  = 8;
  localparam int unsigned SW  = 6;
  localparam int unsigned LAW = 26;
  localparam int unsigned BL  = 2;
  localparam int unsigned MX  = 4;
  localparam int unsigned FD  = 8;

  logic clk;
  logic rst_i;
  logic htu_arvalid, htu_arready, htu_awvalid, htu_awready;
  logic [LAW-1:0] htu_araddr, htu_awaddr;
  logic [SW-1:0]  htu_sw;
  logic sc_valid, sc_ready;
  logic [DW-1:0] sc_data;
  logic [DW/8-1:0] sc_strb;
  logic [SW-1:0] sc_sw;
  logic isu_rvalid, isu_rready, isu_rlast;
  logic [DW-1:0] isu_rdata;
  logic [IW-1:0] isu_rid;
  logic arvalid, arready, awvalid, awready;
  logic [IW-1:0] arid, awid;
  logic [AW-1:0] araddr, awaddr;
  logic [3:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic rvalid, rready, rlast;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic wvalid, wready, wlast;
  logic [IW-1:0] wid;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic bvalid, bready;
  logic [IW-1:0] bid;
  logic [1:0] bresp;
  logic err;
  logic [IW-1:0] err_id;
  logic [1:0] err_resp;

  bank_biu_burst dut (
    .clk_i(clk), .rst_i(rst_i),
    .htu_biu_arvalid_i(htu_arvalid), .htu_biu_arready_o(htu_arready), .htu_biu_araddr_i(htu_araddr),
    .htu_biu_awvalid_i(htu_awvalid), .htu_biu_awready_o(htu_awready), .htu_biu_awaddr_i(htu_awaddr),
    .htu_biu_set_way_i(htu_sw),
    .sc_biu_valid_i(sc_valid), .sc_biu_ready_o(sc_ready), .sc_biu_data_i(sc_data),
    .sc_biu_strb_i(sc_strb), .sc_biu_set_way_i(sc_sw),
    .biu_isu_rvalid_o(isu_rvalid), .biu_isu_rready_i(isu_rready), .biu_isu_rdata_o(isu_rdata),
    .biu_isu_rid_o(isu_rid), .biu_isu_rlast_o(isu_rlast),
    .biu_axi3_arvalid_o(arvalid), .biu_axi3_arready_i(arready), .biu_axi3_arid_o(arid),
    .biu_axi3_araddr_o(araddr), .biu_axi3_arlen_o(arlen), .biu_axi3_arsize_o(arsize),
    .biu_axi3_arburst_o(arburst),
    .biu_axi3_rvalid_i(rvalid), .biu_axi3_rready_o(rready), .biu_axi3_rid_i(rid),
    .biu_axi3_rdata_i(rdata), .biu_axi3_rresp_i(rresp), .biu_axi3_rlast_i(rlast),
    .biu_axi3_awvalid_o(awvalid), .biu_axi3_awready_i(awready), .biu_axi3_awid_o(awid),
    .biu_axi3_awaddr_o(awaddr), .biu_axi3_awlen_o(awlen), .biu_axi3_awsize_o(awsize),
    .biu_axi3_awburst_o(awburst),
    .biu_axi3_wvalid_o(wvalid), .biu_axi3_wready_i(wready), .biu_axi3_wid_o(wid),
    .biu_axi3_wdata_o(wdata), .biu_axi3_wstrb_o(wstrb), .biu_axi3_wlast_o(wlast),
    .biu_axi3_bvalid_i(bvalid), .biu_axi3_bready_o(bready), .biu_axi3_bid_i(bid),
    .biu_axi3_bresp_i(bresp),
    .biu_err_o(err), .biu_err_id_o(err_id), .biu_err_resp_o(err_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n;

`ifdef BIU_ERR_CAPTURE_EN
  localparam logic [IW-1:0] EXP_ERR_ID   = 8'h03;
  localparam logic [1:0]    EXP_ERR_RESP = 2'b10;
`else
  localparam logic [IW-1:0] EXP_ERR_ID   = 8'h00;
  localparam logic [1:0]    EXP_ERR_RESP = 2'b00;
`endif

  typedef struct {
    bit             is_wr;
    logic [LAW-1:0] line;
    logic [SW-1:0]  sw;
    logic [AW-1:0]  exp_addr;
    logic [IW-1:0]  exp_id;
  } vec_t;

  typedef struct {
    bit             is_wr;
    logic [SW-1:0]  sw;
    logic [LAW-1:0] line;
  } mreq_t;

  // Reference model state for the random phase
  mreq_t         mfifo[$];
  logic [IW-1:0] rdq[$];
  logic [IW-1:0] wq[$];
  logic [IW-1:0] bq[$];
  int            rbeat;
  int            wbeat;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle();
    htu_arvalid = 0; htu_awvalid = 0; htu_araddr = '0; htu_awaddr = '0; htu_sw = '0;
    sc_valid = 0; sc_data = '0; sc_strb = '0; sc_sw = '0;
    isu_rready = 1;
    arready = 0; awready = 0;
    rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
    wready = 0;
    bvalid = 0; bid = '0; bresp = '0;
  endtask

  task automatic push_req(input bit is_wr, input logic [LAW-1:0] line, input logic [SW-1:0] sw);
    htu_sw = sw;
    if (is_wr) begin htu_awvalid = 1; htu_awaddr = line; end
    else       begin htu_arvalid = 1; htu_araddr = line; end
    settle();
    chk(is_wr ? "awready_push" : "arready_push", is_wr ? htu_awready : htu_arready, 1);
    cyc();
    htu_arvalid = 0; htu_awvalid = 0;
  endtask

  task automatic issue_check(input bit is_wr, input logic [AW-1:0] ea, input logic [IW-1:0] eid);
    if (is_wr) awready = 1; else arready = 1;
    settle();
    if (is_wr) begin
      chk("awvalid", awvalid, 1); chk("awaddr", awaddr, ea); chk("awid", awid, eid);
      chk("awlen", awlen, 1); chk("awsize", awsize, 5); chk("awburst", awburst, 1);
      chk("arvalid_wr", arvalid, 0);
    end else begin
      chk("arvalid", arvalid, 1); chk("araddr", araddr, ea); chk("arid", arid, eid);
      chk("arlen", arlen, 1); chk("arsize", arsize, 5); chk("arburst", arburst, 1);
      chk("awvalid_rd", awvalid, 0);
    end
    cyc();
    arready = 0; awready = 0;
  endtask

  task automatic send_r(input logic [IW-1:0] id, input logic [1:0] last_resp);
    for (int b = 0; b < BL; b++) begin
      rvalid = 1; rid = id; rdata = rnd_data(); rlast = (b == BL - 1);
      rresp = (b == BL - 1) ? last_resp : 2'b00; isu_rready = 1;
      settle();
      chk("isu_rvalid", isu_rvalid, 1); chk("isu_rdata", isu_rdata, rdata);
      chk("isu_rid", isu_rid, id); chk("isu_rlast", isu_rlast, (b == BL - 1));
      chk("rready", rready, 1);
      cyc();
    end
    rvalid = 0; rlast = 0; rresp = 0;
  endtask

  task automatic send_w(input logic [SW-1:0] sw);
    for (int b = 0; b < BL; b++) begin
      sc_valid = 1; sc_data = rnd_data(); sc_strb = $urandom; sc_sw = sw; wready = 1;
      settle();
      chk("wvalid", wvalid, 1); chk("sc_ready", sc_ready, 1);
      chk("wlast", wlast, (b == BL - 1)); chk("wid", wid, {2'b00, sw});
      chk("wdata", wdata, sc_data); chk("wstrb", wstrb, sc_strb);
      cyc();
    end
    sc_valid = 0; wready = 0;
  endtask

  task automatic send_b(input logic [IW-1:0] id, input logic [1:0] resp);
    bvalid = 1; bid = id; bresp = resp;
    settle();
    chk("bready", bready, 1);
    cyc();
    bvalid = 0; bresp = 0;
  endtask

  // One randomized cycle: drive, compare against the model, advance the model
  task automatic rand_cycle(input bit allow_push);
    mreq_t h;
    bit exp_rdy, exp_arv, exp_awv, exp_wv, hv;
    htu_arvalid = allow_push && ($urandom % 3 == 0);
    htu_awvalid = allow_push && ($urandom % 3 == 0);
    htu_araddr  = LAW'($urandom); htu_awaddr = LAW'($urandom); htu_sw = SW'($urandom);
    arready = ($urandom % 4 != 0); awready = ($urandom % 4 != 0);
    sc_valid = $urandom % 2; sc_data = rnd_data(); sc_strb = $urandom;
    sc_sw = SW'($urandom);
    if (wq.size() > 0) sc_sw = wq[0][SW-1:0];
    wready = ($urandom % 4 != 0);
    rvalid = (rdq.size() > 0) && ($urandom % 2 == 1);
    rid = '0;
    if (rdq.size() > 0) rid = rdq[0];
    rlast = (rbeat == BL - 1); rresp = 0; rdata = rnd_data();
    isu_rready = ($urandom % 4 != 0);
    bvalid = (bq.size() > 0) && ($urandom % 2 == 1);
    bid = '0;
    if (bq.size() > 0) bid = bq[0];
    bresp = 0;
    settle();

    exp_rdy = (FD - mfifo.size()) >= 2;
    hv = mfifo.size() > 0;
    if (hv) h = mfifo[0];
    exp_arv = hv && !h.is_wr && (rdq.size() < MX);
    exp_awv = hv && h.is_wr && ((wq.size() + bq.size()) < MX) && (wq.size() < MX);
    exp_wv  = sc_valid && (wq.size() > 0);
    chk("r_arready", htu_arready, exp_rdy);
    chk("r_awready", htu_awready, exp_rdy);
    chk("r_arvalid", arvalid, exp_arv);
    chk("r_awvalid", awvalid, exp_awv);
    if (exp_arv) begin chk("r_araddr", araddr, {h.line, 6'b0}); chk("r_arid", arid, {2'b00, h.sw}); end
    if (exp_awv) begin chk("r_awaddr", awaddr, {h.line, 6'b0}); chk("r_awid", awid, {2'b00, h.sw}); end
    chk("r_wvalid", wvalid, exp_wv);
    chk("r_sc_ready", sc_ready, wready && (wq.size() > 0));
    if (exp_wv) begin chk("r_wlast", wlast, wbeat == BL - 1); chk("r_wid", wid, {2'b00, sc_sw}); end
    chk("r_isu_rvalid", isu_rvalid, rvalid);
    chk("r_rready", rready, isu_rready);

    if (exp_arv && arready) begin void'(mfifo.pop_front()); rdq.push_back({2'b00, h.sw}); end
    if (exp_awv && awready) begin void'(mfifo.pop_front()); wq.push_back({2'b00, h.sw}); end
    if (rvalid && isu_rready) begin
      if (rbeat == BL - 1) begin void'(rdq.pop_front()); rbeat = 0; end
      else rbeat++;
    end
    if (exp_wv && wready) begin
      if (wbeat == BL - 1) begin bq.push_back(wq.pop_front()); wbeat = 0; end
      else wbeat++;
    end
    if (bvalid) void'(bq.pop_front());
    if (htu_awvalid && exp_rdy) mfifo.push_back('{1'b1, htu_sw, htu_awaddr});
    if (htu_arvalid && exp_rdy) mfifo.push_back('{1'b0, htu_sw, htu_araddr});
    cyc();
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{1'b0, 26'h000_1234, 6'h05, 32'h0004_8D00, 8'h05};
    tbl[1] = '{1'b1, 26'h3FF_FFFF, 6'h3F, 32'hFFFF_FFC0, 8'h3F};
    tbl[2] = '{1'b0, 26'h000_0000, 6'h00, 32'h0000_0000, 8'h00};
    tbl[3] = '{1'b1, 26'h2AA_AAAA, 6'h2A, 32'hAAAA_AA80, 8'h2A};

    idle();
    rst_i = 1;
    cyc(); cyc();
    rst_i = 0;
    cyc();
    settle();
    chk("rst_arvalid", arvalid, 0); chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);   chk("rst_sc_ready", sc_ready, 0);
    chk("rst_isu_rvalid", isu_rvalid, 0);
    chk("rst_err", err, 0); chk("rst_err_id", err_id, 0); chk("rst_err_resp", err_resp, 0);
    chk("rst_arready", htu_arready, 1); chk("rst_awready", htu_awready, 1);
    chk("rst_bready", bready, 1);

    // Table of single transactions
    for (int i = 0; i < 4; i++) begin
      push_req(tbl[i].is_wr, tbl[i].line, tbl[i].sw);
      issue_check(tbl[i].is_wr, tbl[i].exp_addr, tbl[i].exp_id);
      if (tbl[i].is_wr) begin send_w(tbl[i].sw); send_b(tbl[i].exp_id, 2'b00); end
      else send_r(tbl[i].exp_id, 2'b00);
    end

    // AR and AW in the same cycle: AW is older
    htu_arvalid = 1; htu_awvalid = 1; htu_araddr = 26'h111; htu_awaddr = 26'h222; htu_sw = 6'd9;
    settle();
    chk("dual_arready", htu_arready, 1);
    cyc();
    htu_arvalid = 0; htu_awvalid = 0;
    settle();
    chk("dual_first_aw", awvalid, 1); chk("dual_first_noar", arvalid, 0);
    chk("dual_awaddr", awaddr, 32'h0000_8880);
    awready = 1;
    cyc();
    awready = 0;
    settle();
    chk("dual_then_ar", arvalid, 1); chk("dual_then_noaw", awvalid, 0);
    chk("dual_araddr", araddr, 32'h0000_4440);
    arready = 1;
    cyc();
    arready = 0;
    send_w(6'd9); send_b(8'd9, 2'b00); send_r(8'd9, 2'b00);

    // Fill FIFO to 7 entries, then check the outstanding-read limit
    for (int i = 0; i < 7; i++) push_req(1'b0, LAW'(i + 16), SW'(i));
    settle();
    chk("full_arready", htu_arready, 0); chk("full_awready", htu_awready, 0);
    arready = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      n += int'(arvalid);
      cyc();
    end
    chk("ar_limit", n, 4);
    settle();
    chk("ar_stall", arvalid, 0);
    send_r(8'd0, 2'b00);
    settle();
    chk("ar_after_rlast", arvalid, 1);
    for (int i = 1; i < 7; i++) send_r(IW'(i), 2'b00);
    settle();
    chk("drain_arvalid", arvalid, 0); chk("drain_arready", htu_arready, 1);
    arready = 0;

    // SC beats before AW must be held off
    sc_valid = 1; wready = 1; sc_sw = 6'd4; sc_data = rnd_data();
    settle();
    chk("early_sc_ready", sc_ready, 0); chk("early_wvalid", wvalid, 0);
    cyc();
    push_req(1'b1, 26'h77, 6'd4);
    settle();
    chk("early_wvalid_aw", wvalid, 0);
    issue_check(1'b1, 32'h0000_1DC0, 8'h04);
    send_w(6'd4); send_b(8'h04, 2'b00);

    // Error reporting: B error first, then an R error
    push_req(1'b1, 26'h55, 6'd3);
    issue_check(1'b1, 32'h0000_1540, 8'h03);
    send_w(6'd3);
    send_b(8'h03, 2'b10);
    settle();
    chk("err_b", err, 1); chk("err_id_b", err_id, EXP_ERR_ID); chk("err_resp_b", err_resp, EXP_ERR_RESP);
    push_req(1'b0, 26'h56, 6'd7);
    issue_check(1'b0, 32'h0000_1580, 8'h07);
    send_r(8'h07, 2'b11);
    settle();
    chk("err_sticky", err, 1); chk("err_id_held", err_id, EXP_ERR_ID);
    chk("err_resp_held", err_resp, EXP_ERR_RESP);

    // Reset in the middle of a W burst
    push_req(1'b1, 26'h99, 6'd2);
    issue_check(1'b1, 32'h0000_2640, 8'h02);
    sc_valid = 1; wready = 1; sc_sw = 6'd2;
    settle();
    chk("mid_wlast0", wlast, 0);
    cyc();
    rst_i = 1;
    cyc();
    rst_i = 0;
    settle();
    chk("mrst_wvalid", wvalid, 0); chk("mrst_sc_ready", sc_ready, 0);
    chk("mrst_arvalid", arvalid, 0); chk("mrst_awvalid", awvalid, 0);
    chk("mrst_err", err, 0); chk("mrst_arready", htu_arready, 1);
    sc_valid = 0; wready = 0;
    cyc();
    push_req(1'b1, 26'h9A, 6'd2);
    issue_check(1'b1, 32'h0000_2680, 8'h02);
    send_w(6'd2); send_b(8'h02, 2'b00);

    // Randomized traffic against the queue model
    rbeat = 0; wbeat = 0;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (mfifo.size() + rdq.size() + wq.size() + bq.size() == 0) break;
      rand_cycle(1'b0);
    end
    chk("rand_drain", mfifo.size() + rdq.size() + wq.size() + bq.size(), 0);
    idle();
    settle();
    chk("rand_end_arready", htu_arready, 1); chk("rand_end_wvalid", wvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
